// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer that turns the FFT's bit-reversed
// output stream into natural bin order behind a valid/ready output port.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    output logic                  out_val,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic                  out_last,
    output logic                  overflow
);

    localparam int LOG2N = $clog2(N_POINTS);
    localparam logic [LOG2N-1:0] CNT_MAX = LOG2N'(N_POINTS - 1);

    logic [2*DATA_WIDTH-1:0] mem [2][N_POINTS];

    logic             wr_sel;
    logic             rd_sel;
    logic [LOG2N-1:0] wr_cnt;
    logic [LOG2N-1:0] rd_cnt;
    logic [1:0]       bank_full;
    logic [1:0]       bank_full_nxt;

    logic                  wr_en;
    logic                  wr_last;
    logic                  rd_en;
    logic                  rd_last;
    logic [LOG2N-1:0]      rd_addr;
    logic [2*DATA_WIDTH-1:0] rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Write into the open bank; read the full bank into the output stage
    // whenever that stage is empty or being drained this cycle.
    always_comb begin
        wr_en   = in_val && !bank_full[wr_sel];
        wr_last = wr_en && (wr_cnt == CNT_MAX);
        rd_en   = bank_full[rd_sel] && (!out_val || out_ready);
        rd_last = rd_en && (rd_cnt == CNT_MAX);
        rd_addr = bitrev(rd_cnt);
        rd_word = mem[rd_sel][rd_addr];
    end

    // Frame completion marks its bank full; final readout frees the other.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_last) begin
            bank_full_nxt[wr_sel] = 1'b1;
        end
        if (rd_last) begin
            bank_full_nxt[rd_sel] = 1'b0;
        end
    end

    // Sample storage, intentionally left unreset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_sel][wr_cnt] <= {in_re, in_im};
        end
    end

    // Write pointer, bank toggle and sticky drop flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_sel   <= 1'b0;
            wr_cnt   <= '0;
            overflow <= 1'b0;
        end else if (wr_en) begin
            wr_cnt <= wr_cnt + LOG2N'(1);
            if (wr_last) begin
                wr_sel <= ~wr_sel;
            end
        end else if (in_val) begin
            overflow <= 1'b1;
        end
    end

    // Bank occupancy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_full <= 2'b00;
        end else begin
            bank_full <= bank_full_nxt;
        end
    end

    // Output register stage with hold-while-stalled behaviour.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_sel   <= 1'b0;
            rd_cnt   <= '0;
            out_val  <= 1'b0;
            out_last <= 1'b0;
            out_re   <= '0;
            out_im   <= '0;
        end else if (rd_en) begin
            out_re   <= rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
            out_im   <= rd_word[DATA_WIDTH-1:0];
            out_val  <= 1'b1;
            out_last <= (rd_cnt == CNT_MAX);
            rd_cnt   <= rd_cnt + LOG2N'(1);
            if (rd_last) begin
                rd_sel <= ~rd_sel;
            end
        end else if (out_ready) begin
            out_val  <= 1'b0;
            out_last <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb_fft_bitrev_reorder: directed and randomized checks of the reorder
// buffer against a frame-level reordering model.
module tb_fft_bitrev_reorder;

    localparam int DW = 16;
    localparam int N  = 16;
    localparam int LN = 4;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic          last;
    } smp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_val = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;
    logic          out_val;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic          out_last;
    logic          overflow;

    logic          sw_val = 1'b0;
    logic [DW-1:0] sw_re = '0;
    logic [DW-1:0] sw_im = '0;
    logic          sw_rdy = 1'b1;
    logic          o4_val, o4_last, o4_ovf;
    logic [DW-1:0] o4_re, o4_im;
    logic          o64_val, o64_last, o64_ovf;
    logic [DW-1:0] o64_re, o64_im;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_out = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    bit mark_first = 0;
    bit held = 0;
    logic [DW-1:0] h_re, h_im;
    logic          h_last;

    smp_t exp_q[$];
    smp_t part[$];
    logic [2*DW:0] q4[$];
    logic [2*DW:0] q64[$];

    always #5 clk = ~clk;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) u_dut (
        .clk(clk), .rst(rst),
        .in_val(in_val), .in_re(in_re), .in_im(in_im),
        .out_val(out_val), .out_ready(out_ready),
        .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .overflow(overflow)
    );

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(4)) u_n4 (
        .clk(clk), .rst(rst),
        .in_val(sw_val), .in_re(sw_re), .in_im(sw_im),
        .out_val(o4_val), .out_ready(sw_rdy),
        .out_re(o4_re), .out_im(o4_im),
        .out_last(o4_last), .overflow(o4_ovf)
    );

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(64)) u_n64 (
        .clk(clk), .rst(rst),
        .in_val(sw_val), .in_re(sw_re), .in_im(sw_im),
        .out_val(o64_val), .out_ready(sw_rdy),
        .out_re(o64_re), .out_im(o64_im),
        .out_last(o64_last), .overflow(o64_ovf)
    );

    function automatic int brev(input int k, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (k[i]) r |= 1 << (bits - 1 - i);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Natural-order output of a frame: bin k is input sample bitrev(k).
    task automatic model_in(input logic [DW-1:0] re, input logic [DW-1:0] im);
        smp_t s;
        s.re = re;
        s.im = im;
        s.last = 1'b0;
        part.push_back(s);
        if (part.size() == N) begin
            for (int k = 0; k < N; k++) begin
                s = part[brev(k, LN)];
                s.last = (k == N - 1);
                exp_q.push_back(s);
            end
            part.delete();
        end
    endtask

    task automatic tick();
        smp_t e;
        if (held) begin
            chk("hold_val", out_val, 1);
            chk("hold_re", out_re, h_re);
            chk("hold_im", out_im, h_im);
            chk("hold_last", out_last, h_last);
        end
        if (out_val === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("extra_out", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("out_re", out_re, e.re);
                chk("out_im", out_im, e.im);
                chk("out_last", out_last, e.last);
                n_out++;
                last_cyc = cyc;
                if (mark_first) begin
                    first_cyc = cyc;
                    mark_first = 0;
                end
            end
        end
        held = (out_val === 1'b1) && (out_ready === 1'b0);
        h_re = out_re;
        h_im = out_im;
        h_last = out_last;
        if (o4_val === 1'b1) q4.push_back({o4_last, o4_im, o4_re});
        if (o64_val === 1'b1) q64.push_back({o64_last, o64_im, o64_re});
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic feed(input logic [DW-1:0] re, input logic [DW-1:0] im,
                        input bit keep);
        in_val = 1'b1;
        in_re = re;
        in_im = im;
        if (keep) model_in(re, im);
        tick();
        in_val = 1'b0;
    endtask

    task automatic drain(input int lim);
        int i = 0;
        while (exp_q.size() > 0 && i < lim) begin
            tick();
            i++;
        end
        chk("drain_done", exp_q.size(), 0);
    endtask

    initial begin
        bit prev;
        int base;
        int gap;
        int ev;

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_val", out_val, 0);
        chk("rst_last", out_last, 0);
        chk("rst_re", out_re, 0);
        chk("rst_im", out_im, 0);
        chk("rst_ovf", overflow, 0);

        // Single ramp frame with latency check.
        for (int k = 0; k < N; k++) feed(DW'(k), DW'(16'h100 + k), 1);
        chk("lat_c1", out_val, 0);
        tick();
        chk("lat_c2", out_val, 1);
        chk("first_bin", out_re, 0);
        drain(100);
        repeat (3) tick();

        // Four frames back to back.
        mark_first = 1;
        for (int k = 0; k < 4 * N; k++) feed(DW'($urandom), DW'($urandom), 1);
        drain(200);
        chk("b2b_gapless", last_cyc - first_cyc, 4 * N - 1);
        chk("b2b_ovf", overflow, 0);

        // Alternating backpressure during readout.
        for (int k = 0; k < N; k++) feed(DW'($urandom), DW'($urandom), 1);
        for (int i = 0; i < 4 * N && exp_q.size() > 0; i++) begin
            out_ready = (i % 2 == 0);
            tick();
        end
        out_ready = 1'b1;
        drain(50);

        // Overflow: third frame arrives with both banks full.
        out_ready = 1'b0;
        for (int k = 0; k < 2 * N; k++) feed(DW'($urandom), DW'($urandom), 1);
        chk("ovf_pre", overflow, 0);
        feed(DW'($urandom), DW'($urandom), 0);
        chk("ovf_rise", overflow, 1);
        for (int k = 1; k < N; k++) feed(DW'($urandom), DW'($urandom), 0);
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b1;
        drain(100);
        repeat (3) tick();
        chk("ovf_hold", overflow, 1);

        // Reset while output index 5 is presented.
        for (int k = 0; k < N; k++) feed(DW'($urandom), DW'($urandom), 1);
        base = n_out;
        for (int i = 0; i < 100 && n_out < base + 5; i++) tick();
        chk("rst_idx", n_out - base, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        part.delete();
        chk("rst_mid_val", out_val, 0);
        chk("rst_mid_ovf", overflow, 0);
        for (int k = 0; k < N; k++) feed(DW'(k + 32), DW'(k), 1);
        tick();
        chk("rst_new_bin0", out_re, 32);
        drain(100);

        // Randomized gaps and stalls, never overrunning the banks.
        prev = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                gap = $urandom_range(2, 4);
                for (int g = 0; g < gap; g++) begin
                    out_ready = ($urandom_range(0, 1) == 1) || !prev;
                    prev = out_ready;
                    tick();
                end
                out_ready = ($urandom_range(0, 1) == 1) || !prev;
                prev = out_ready;
                feed(DW'($urandom), DW'($urandom), 1);
            end
        end
        out_ready = 1'b1;
        drain(200);
        chk("rand_ovf", overflow, 0);

        // Ramp into the 4- and 64-point instances.
        for (int k = 0; k < 64; k++) begin
            sw_val = 1'b1;
            sw_re = DW'(k);
            tick();
        end
        sw_val = 1'b0;
        repeat (80) tick();
        chk("sw4_cnt", q4.size(), 64);
        chk("sw64_cnt", q64.size(), 64);
        for (int n = 0; n < q4.size(); n++) begin
            ev = (n / 4) * 4 + brev(n % 4, 2);
            chk("sw4_re", q4[n][DW-1:0], ev);
            chk("sw4_last", q4[n][2*DW], (n % 4 == 3));
        end
        for (int n = 0; n < q64.size(); n++) begin
            chk("sw64_re", q64[n][DW-1:0], brev(n, 6));
            chk("sw64_last", q64[n][2*DW], (n == 63));
        end
        chk("sw4_ovf", o4_ovf, 0);
        chk("sw64_ovf", o64_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
